// File: rtl/slllcc_pkg.sv
// ============================================================================
// Module  : slllcc_pkg
// Brief   : Shared defaults, shift-width helper and data-word type for SLLLCC.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package slllcc_pkg;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int sw_of(input int width);
        return $clog2(width);
    endfunction

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

`default_nettype wire

// File: rtl/slllcc_stage.sv
// ============================================================================
// Module  : slllcc_stage
// Brief   : One barrel-shifter level: shifts left by SHIFT when en is high.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module slllcc_stage #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    output logic [WIDTH-1:0] dout
);

    assign dout = en ? (din << SHIFT) : din;

endmodule

`default_nettype wire

// File: rtl/slllcc.sv
// ============================================================================
// Module  : slllcc
// Brief   : Registered logical-left barrel shifter with zero flag.
//           Define SLLLCC_PIPE_EN to add a mid-chain pipeline register.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module slllcc
    import slllcc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SW    = sw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [SW-1:0]    s,
    input  logic             in_valid,
    output logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             zero
);

    // CUT is the first stage fed from the pipeline register; SW means "no cut".
`ifdef SLLLCC_PIPE_EN
    localparam int CUT = SW / 2 + 1;
`else
    localparam int CUT = SW;
`endif

    logic [WIDTH-1:0] w_in  [SW];
    logic [WIDTH-1:0] w_out [SW];
    logic [SW-1:0]    w_en;
    logic             w_valid;

    generate
        for (genvar k = 0; k < SW; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_in[k] = A;
            end else if (k != CUT) begin : g_link
                assign w_in[k] = w_out[k-1];
            end

            slllcc_stage #(
                .WIDTH (WIDTH),
                .SHIFT (1 << k)
            ) u_stage (
                .din  (w_in[k]),
                .en   (w_en[k]),
                .dout (w_out[k])
            );
        end
    endgenerate

`ifdef SLLLCC_PIPE_EN
    logic [WIDTH-1:0]  r_pipe_data;
    logic [SW-CUT-1:0] r_pipe_s;
    logic              r_pipe_valid;

    // Upper shift bits travel with the partial result so later stages see
    // the amount belonging to the same operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_data  <= '0;
            r_pipe_s     <= '0;
            r_pipe_valid <= 1'b0;
        end else begin
            r_pipe_data  <= w_out[CUT-1];
            r_pipe_s     <= s[SW-1:CUT];
            r_pipe_valid <= in_valid;
        end
    end

    assign w_in[CUT] = r_pipe_data;
    assign w_en      = {r_pipe_s, s[CUT-1:0]};
    assign w_valid   = r_pipe_valid;
`else
    assign w_en    = s;
    assign w_valid = in_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            B         <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b0;
        end else begin
            out_valid <= w_valid;
            if (w_valid) begin
                B    <= w_out[SW-1];
                zero <= (w_out[SW-1] == '0);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_slllcc.sv
// ============================================================================
// Module  : tb_slllcc
// Brief   : Self-checking bench for slllcc (honours SLLLCC_PIPE_EN latency).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slllcc;

    localparam int WIDTH = 32;
    localparam int SW    = $clog2(WIDTH);
`ifdef SLLLCC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] A = '0;
    logic [SW-1:0]    s = '0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             zero;

    slllcc #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .s         (s),
        .in_valid  (in_valid),
        .B         (B),
        .out_valid (out_valid),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    // Reference: a left shift by s is multiplication by 2**s, modulo 2**WIDTH.
    function automatic logic [WIDTH-1:0] ref_shl(input logic [WIDTH-1:0] a, input logic [SW-1:0] sh);
        logic [2*WIDTH-1:0] wide;
        logic [2*WIDTH-1:0] pow2;
        pow2 = '0;
        pow2[sh] = 1'b1;
        wide = {{WIDTH{1'b0}}, a} * pow2;
        return wide[WIDTH-1:0];
    endfunction

    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_b     = '0;
    logic             m_zero  = 1'b0;
    logic             ov;
    logic [WIDTH-1:0] ob;
`ifdef SLLLCC_PIPE_EN
    logic             mid_v = 1'b0;
    logic [WIDTH-1:0] mid_b = '0;
`endif

    always @(posedge clk) begin
        if (rst) begin
`ifdef SLLLCC_PIPE_EN
            mid_v = 1'b0;
            mid_b = '0;
`endif
            m_valid = 1'b0;
            m_b     = '0;
            m_zero  = 1'b0;
        end else begin
`ifdef SLLLCC_PIPE_EN
            ov    = mid_v;
            ob    = mid_b;
            mid_v = in_valid;
            mid_b = ref_shl(A, s);
`else
            ov = in_valid;
            ob = ref_shl(A, s);
`endif
            m_valid = ov;
            if (ov) begin
                m_b    = ob;
                m_zero = (ob == '0);
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            vectors++;
            if (out_valid !== m_valid || B !== m_b || zero !== m_zero) begin
                miscompares++;
                $display("FAIL model @%0t: got v=%b B=%h z=%b, expected v=%b B=%h z=%b",
                         $time, out_valid, B, zero, m_valid, m_b, m_zero);
            end
        end
    end

    task automatic cyc(input logic r, input logic v, input logic [WIDTH-1:0] a, input logic [SW-1:0] sh);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        A        = a;
        s        = sh;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, WIDTH'($urandom), SW'($urandom));
    endtask

    task automatic lit(input string name, input logic v, input logic [WIDTH-1:0] b, input logic z);
        vectors++;
        if (out_valid !== v || B !== b || zero !== z) begin
            miscompares++;
            $display("FAIL %s: got v=%b B=%h z=%b, expected v=%b B=%h z=%b",
                     name, out_valid, B, zero, v, b, z);
        end
    endtask

    task automatic op(input string name, input logic [WIDTH-1:0] a, input logic [SW-1:0] sh,
                      input logic [WIDTH-1:0] exp_b, input logic exp_z);
        cyc(1'b0, 1'b1, a, sh);
        repeat (LAT) idle();
        lit(name, 1'b1, exp_b, exp_z);
    endtask

    initial begin
        cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, 32'hDEADBEEF, 5'd3);
        checking = 1'b1;
        lit("reset_state", 1'b0, 32'h0, 1'b0);

        op("s8",        32'h3FF98732, 5'd8,  32'hF9873200, 1'b0);
        idle();
        lit("idle_hold", 1'b0, 32'hF9873200, 1'b0);
        op("s0",        32'h3FF98732, 5'd0,  32'h3FF98732, 1'b0);
        op("one_s31",   32'h00000001, 5'd31, 32'h80000000, 1'b0);
        op("zero_s31",  32'h3FF98732, 5'd31, 32'h00000000, 1'b1);
        op("ones_s31",  32'hFFFFFFFF, 5'd31, 32'h80000000, 1'b0);
        op("s4",        32'h00000081, 5'd4,  32'h00000810, 1'b0);
        op("s16",       32'hA5A51234, 5'd16, 32'h12340000, 1'b0);
        op("zero_in",   32'h00000000, 5'd7,  32'h00000000, 1'b1);

        for (int j = 0; j < 6; j++) begin
            if (j < 3) cyc(1'b0, 1'b1, 32'h1, SW'(j + 1));
            else       idle();
            if (j - LAT >= 0 && j - LAT < 3)
                lit("b2b", 1'b1, WIDTH'(32'h1 << (j - LAT + 1)), 1'b0);
            else if (j - LAT == 3)
                lit("b2b_idle", 1'b0, 32'h8, 1'b0);
        end

        cyc(1'b0, 1'b1, 32'h5, 5'd1);
        cyc(1'b1, 1'b1, 32'h7, 5'd2);
        idle();
        lit("rst_flush", 1'b0, 32'h0, 1'b0);
        idle();
        idle();
        lit("rst_no_stale", 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                WIDTH'($urandom), SW'($urandom));
        end
        repeat (LAT + 2) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
